// File: rtl/iob_asym_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// iob_asym_fifo_ctrl_if
//   Control bundle between a FIFO user and the asymmetric FIFO controller.
//   Its parameters must match the parameters of the controller it is bound to.
//
//   Handshake: a write is accepted in a cycle where w_req=1, w_full=0 and
//   clear=0. A read is accepted in a cycle where r_req=1, r_empty=0 and
//   clear=0. w_full and r_empty act as registered "not ready" flags, and
//   mem_w_en / mem_r_en are the accept strobes. Read data from the RAM is
//   valid one cycle after mem_r_en, when r_valid=1.
//
//   Signals (direction seen from the controller / slave side):
//     clear       in   synchronous flush of pointers, level and flags
//     w_req       in   write request
//     r_req       in   read request
//     w_full      out  write side cannot accept
//     r_empty     out  read side cannot deliver
//     r_valid     out  RAM read data valid this cycle
//     level       out  occupancy in narrow units
//     overflow    out  sticky: write attempted while full
//     underflow   out  sticky: read attempted while empty
//     mem_w_en    out  RAM write enable
//     mem_w_addr  out  RAM write address (wide-word units on the write side)
//     mem_r_en    out  RAM read enable
//     mem_r_addr  out  RAM read address (word units on the read side)
// ---------------------------------------------------------------------------
interface iob_asym_fifo_ctrl_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
);
  localparam int MIN_W    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_RATIO  = W_DATA_W / MIN_W;
  localparam int R_RATIO  = R_DATA_W / MIN_W;
  localparam int W_ADDR_W = ADDR_W - $clog2(W_RATIO);
  localparam int R_ADDR_W = ADDR_W - $clog2(R_RATIO);

  logic                clear;
  logic                w_req;
  logic                r_req;
  logic                w_full;
  logic                r_empty;
  logic                r_valid;
  logic [ADDR_W:0]     level;
  logic                overflow;
  logic                underflow;
  logic                mem_w_en;
  logic [W_ADDR_W-1:0] mem_w_addr;
  logic                mem_r_en;
  logic [R_ADDR_W-1:0] mem_r_addr;

  // User side: issues requests, observes status and RAM strobes.
  modport master (
    output clear, w_req, r_req,
    input  w_full, r_empty, r_valid, level, overflow, underflow,
    input  mem_w_en, mem_w_addr, mem_r_en, mem_r_addr
  );

  // Controller side.
  modport slave (
    input  clear, w_req, r_req,
    output w_full, r_empty, r_valid, level, overflow, underflow,
    output mem_w_en, mem_w_addr, mem_r_en, mem_r_addr
  );
endinterface

// File: rtl/iob_asym_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// iob_asym_fifo_ctrl
//   Pointer / level / flag controller for a FIFO built on an asymmetric
//   two-port RAM (write width W_DATA_W, read width R_DATA_W). Data never
//   passes through this block; it only generates RAM enables and addresses
//   and the FIFO status. The RAM packs little-endian: narrow unit k of a wide
//   word lives at bits [(k+1)*MIN_W-1 : k*MIN_W] and at the lower narrow
//   address, so plain incrementing pointers on both sides stay coherent.
//
//   Occupancy is tracked in narrow (MIN_W) units, so a write adds W_RATIO
//   and a read removes R_RATIO. Full/empty decode from the registered level
//   with enough headroom that level always stays within [0, CAP].
//
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset (wins over clear)
//     bus   slave modport of iob_asym_fifo_ctrl_if (requests, status, RAM
//           control); its parameters must equal this module's parameters.
//
//   Parameters: W_DATA_W, R_DATA_W (both MIN_W times a power of two) and
//   ADDR_W (log2 of RAM depth in narrow units, ADDR_W > log2 of the larger
//   ratio).
// ---------------------------------------------------------------------------
module iob_asym_fifo_ctrl #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  iob_asym_fifo_ctrl_if.slave   bus
);

  localparam int MIN_W    = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int W_RATIO  = W_DATA_W / MIN_W;
  localparam int R_RATIO  = R_DATA_W / MIN_W;
  localparam int W_ADDR_W = ADDR_W - $clog2(W_RATIO);
  localparam int R_ADDR_W = ADDR_W - $clog2(R_RATIO);
  localparam int LVL_W    = ADDR_W + 1;

  localparam logic [LVL_W-1:0] CAP      = LVL_W'(2 ** ADDR_W);
  localparam logic [LVL_W-1:0] W_INC    = LVL_W'(W_RATIO);
  localparam logic [LVL_W-1:0] R_DEC    = LVL_W'(R_RATIO);
  // Full as soon as one more wide write would overrun CAP.
  localparam logic [LVL_W-1:0] FULL_THR = CAP - W_INC;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [W_ADDR_W-1:0] w_ptr_q,     w_ptr_d;
  logic [R_ADDR_W-1:0] r_ptr_q,     r_ptr_d;
  logic [LVL_W-1:0]    level_q,     level_d;
  logic                r_valid_q,   r_valid_d;
  logic                overflow_q,  overflow_d;
  logic                underflow_q, underflow_d;

  // -------------------------------------------------------------------------
  // Status decode and accept strobes
  // -------------------------------------------------------------------------
  logic w_full;
  logic r_empty;
  logic w_acc;
  logic r_acc;
  logic w_rej;
  logic r_rej;

  always_comb begin
    w_full  = (level_q > FULL_THR);
    r_empty = (level_q < R_DEC);
    // clear blocks both accepts so a flush cycle never touches the RAM.
    w_acc   = bus.w_req & ~w_full  & ~bus.clear;
    r_acc   = bus.r_req & ~r_empty & ~bus.clear;
    w_rej   = bus.w_req &  w_full  & ~bus.clear;
    r_rej   = bus.r_req &  r_empty & ~bus.clear;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    level_d     = level_q;
    r_valid_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.clear) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Pointers wrap naturally at their own widths.
      if (w_acc) w_ptr_d = w_ptr_q + W_ADDR_W'(1);
      if (r_acc) r_ptr_d = r_ptr_q + R_ADDR_W'(1);
      // Simultaneous accepts net out in one step; the full/empty headroom
      // keeps the intermediate sum inside LVL_W bits.
      level_d     = level_q + (w_acc ? W_INC : '0) - (r_acc ? R_DEC : '0);
      r_valid_d   = r_acc;
      overflow_d  = overflow_q  | w_rej;
      underflow_d = underflow_q | r_rej;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      level_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      level_q     <= level_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.w_full     = w_full;
  assign bus.r_empty    = r_empty;
  assign bus.r_valid    = r_valid_q;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.mem_w_en   = w_acc;
  assign bus.mem_w_addr = w_ptr_q;
  assign bus.mem_r_en   = r_acc;
  assign bus.mem_r_addr = r_ptr_q;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_level_bound: assert property (@(posedge clk) disable iff (rst) level_q <= CAP);
  a_no_wr_full:  assert property (@(posedge clk) disable iff (rst) !(w_acc && w_full));
  a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) !(r_acc && r_empty));

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_asym_fifo_ctrl
//   Directed bench for iob_asym_fifo_ctrl. dut_a uses the default 32->8
//   geometry and is driven from a vector table; dut_b uses 8->32 and is
//   driven by a short hand-written sequence. Each vector's inputs are set
//   after a falling edge, outputs are sampled 1 time unit later (before the
//   next rising edge), so expected values describe the pre-edge state.
// ---------------------------------------------------------------------------
module tb_iob_asym_fifo_ctrl;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  iob_asym_fifo_ctrl_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) a_if ();
  iob_asym_fifo_ctrl_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) b_if ();

  iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if)
  );

  iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if)
  );

  // -------------------------------------------------------------------------
  // Vector table types
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic       wf;
    logic       re;
    logic       rv;
    logic       ov;
    logic       un;
    logic       we;
    logic       ren;
    logic [4:0] lvl;
    logic [1:0] wa;
    logic [3:0] ra;
  } out_t;

  typedef struct {
    string name;
    logic  rst;
    logic  clr;
    logic  w;
    logic  r;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // -------------------------------------------------------------------------
  // Scoreboard helpers
  // -------------------------------------------------------------------------
  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rs, input logic cl,
                              input logic w, input logic r,
                              input logic wf, input logic re, input logic rv,
                              input logic ov, input logic un,
                              input logic we, input logic ren,
                              input int lvl, input int wa, input int ra);
    vec_t v;
    v.name    = n;
    v.rst     = rs;
    v.clr     = cl;
    v.w       = w;
    v.r       = r;
    v.exp.wf  = wf;
    v.exp.re  = re;
    v.exp.rv  = rv;
    v.exp.ov  = ov;
    v.exp.un  = un;
    v.exp.we  = we;
    v.exp.ren = ren;
    v.exp.lvl = 5'(lvl);
    v.exp.wa  = 2'(wa);
    v.exp.ra  = 4'(ra);
    return v;
  endfunction

  function automatic out_t sample_a();
    out_t o;
    o.wf  = a_if.w_full;
    o.re  = a_if.r_empty;
    o.rv  = a_if.r_valid;
    o.ov  = a_if.overflow;
    o.un  = a_if.underflow;
    o.we  = a_if.mem_w_en;
    o.ren = a_if.mem_r_en;
    o.lvl = a_if.level;
    o.wa  = a_if.mem_w_addr;
    o.ra  = a_if.mem_r_addr;
    return o;
  endfunction

  // Called just after a falling edge; leaves the bench after the next one.
  task automatic apply_a(input vec_t v, input int idx);
    rst_a        = v.rst;
    a_if.clear   = v.clr;
    a_if.w_req   = v.w;
    a_if.r_req   = v.r;
    #1;
    check_val($sformatf("%s[%0d]", v.name, idx), 32'(sample_a()), 32'(v.exp));
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Table: (name, rst,clr,w,r, wf,re,rv,ov,un, we,ren, lvl,wa,ra)
  // -------------------------------------------------------------------------
  task automatic build_table();
    vecs.push_back(mk("reset_state", 0,0,0,0, 0,1,0,0,0, 0,0,  0,0,0));
    // Fill with five wide writes; fifth is rejected.
    vecs.push_back(mk("wr1",         0,0,1,0, 0,1,0,0,0, 1,0,  0,0,0));
    vecs.push_back(mk("wr2",         0,0,1,0, 0,0,0,0,0, 1,0,  4,1,0));
    vecs.push_back(mk("wr3",         0,0,1,0, 0,0,0,0,0, 1,0,  8,2,0));
    vecs.push_back(mk("wr4",         0,0,1,0, 0,0,0,0,0, 1,0, 12,3,0));
    vecs.push_back(mk("wr5_rej",     0,0,1,0, 1,0,0,0,0, 0,0, 16,0,0));
    vecs.push_back(mk("full_idle",   0,0,0,0, 1,0,0,1,0, 0,0, 16,0,0));
    // Drain with 17 narrow reads; seventeenth is rejected.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk("rd", 0,0,0,1, ((16 - k) > 12), 0, (k > 0), 1, 0,
                        0,1, 16 - k, 0, k));
    vecs.push_back(mk("rd17_rej",    0,0,0,1, 0,1,1,1,0, 0,0,  0,0,0));
    vecs.push_back(mk("empty_idle",  0,0,0,0, 0,1,0,1,1, 0,0,  0,0,0));
    vecs.push_back(mk("clear",       0,1,0,0, 0,1,0,1,1, 0,0,  0,0,0));
    vecs.push_back(mk("post_clear",  0,0,0,0, 0,1,0,0,0, 0,0,  0,0,0));
    // Simultaneous write and read at level 4.
    vecs.push_back(mk("wr_to4",      0,0,1,0, 0,1,0,0,0, 1,0,  0,0,0));
    vecs.push_back(mk("both_at4",    0,0,1,1, 0,0,0,0,0, 1,1,  4,1,0));
    vecs.push_back(mk("lvl7",        0,0,0,0, 0,0,1,0,0, 0,0,  7,2,1));
    // Reach 12 with overflow set, then clear while writing.
    vecs.push_back(mk("wr_to11",     0,0,1,0, 0,0,0,0,0, 1,0,  7,2,1));
    vecs.push_back(mk("wr_to15",     0,0,1,0, 0,0,0,0,0, 1,0, 11,3,1));
    vecs.push_back(mk("wr_rej15",    0,0,1,0, 1,0,0,0,0, 0,0, 15,0,1));
    vecs.push_back(mk("rd_to14",     0,0,0,1, 1,0,0,1,0, 0,1, 15,0,1));
    vecs.push_back(mk("rd_to13",     0,0,0,1, 1,0,1,1,0, 0,1, 14,0,2));
    vecs.push_back(mk("rd_to12",     0,0,0,1, 1,0,1,1,0, 0,1, 13,0,3));
    vecs.push_back(mk("clr_with_wr", 0,1,1,0, 0,0,1,1,0, 0,0, 12,0,4));
    vecs.push_back(mk("after_clr",   0,0,0,0, 0,1,0,0,0, 0,0,  0,0,0));
    // Reset in mid-transfer (with clear also high) discards occupancy.
    vecs.push_back(mk("mid_wr1",     0,0,1,0, 0,1,0,0,0, 1,0,  0,0,0));
    vecs.push_back(mk("mid_wr2",     0,0,1,0, 0,0,0,0,0, 1,0,  4,1,0));
    vecs.push_back(mk("mid_rd",      0,0,0,1, 0,0,0,0,0, 0,1,  8,2,0));
    vecs.push_back(mk("mid_rst",     1,1,0,0, 0,0,1,0,0, 0,0,  7,2,1));
    vecs.push_back(mk("after_rst",   0,0,0,0, 0,1,0,0,0, 0,0,  0,0,0));
    // Write accepted while the same-cycle read is rejected on empty.
    vecs.push_back(mk("wr_rd_empty", 0,0,1,1, 0,1,0,0,0, 1,0,  0,0,0));
    vecs.push_back(mk("uflow_set",   0,0,0,0, 0,0,0,0,1, 0,0,  4,1,0));
  endtask

  // -------------------------------------------------------------------------
  // Hand-written sequence on the 8->32 instance
  // -------------------------------------------------------------------------
  task automatic run_b();
    for (int k = 0; k < 4; k++) begin
      rst_b      = 1'b0;
      b_if.w_req = 1'b1;
      b_if.r_req = 1'b0;
      #1;
      check_val($sformatf("b_wr%0d_empty", k + 1), 32'(b_if.r_empty), 32'd1);
      check_val($sformatf("b_wr%0d_level", k + 1), 32'(b_if.level), 32'(k));
      check_val($sformatf("b_wr%0d_addr", k + 1), 32'(b_if.mem_w_addr), 32'(k));
      check_val($sformatf("b_wr%0d_en", k + 1), 32'(b_if.mem_w_en), 32'd1);
      @(negedge clk);
    end
    b_if.w_req = 1'b0;
    b_if.r_req = 1'b1;
    #1;
    check_val("b_rd_empty", 32'(b_if.r_empty), 32'd0);
    check_val("b_rd_level", 32'(b_if.level), 32'd4);
    check_val("b_rd_en",    32'(b_if.mem_r_en), 32'd1);
    check_val("b_rd_addr",  32'(b_if.mem_r_addr), 32'd0);
    check_val("b_rd_valid_early", 32'(b_if.r_valid), 32'd0);
    @(negedge clk);
    b_if.r_req = 1'b0;
    #1;
    check_val("b_post_level", 32'(b_if.level), 32'd0);
    check_val("b_post_valid", 32'(b_if.r_valid), 32'd1);
    check_val("b_post_empty", 32'(b_if.r_empty), 32'd1);
    check_val("b_post_addr",  32'(b_if.mem_r_addr), 32'd1);
    @(negedge clk);
    #1;
    check_val("b_valid_drop", 32'(b_if.r_valid), 32'd0);
    check_val("b_no_uflow",   32'(b_if.underflow), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Main
  // -------------------------------------------------------------------------
  initial begin
    rst_a      = 1'b1;
    rst_b      = 1'b1;
    a_if.clear = 1'b0;
    a_if.w_req = 1'b0;
    a_if.r_req = 1'b0;
    b_if.clear = 1'b0;
    b_if.w_req = 1'b0;
    b_if.r_req = 1'b0;

    build_table();
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      apply_a(vecs[i], i);

    run_b();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
